teller_dispatcher: RTL and testbench

TELLER_DISPATCHER -- requirements
Module: teller_dispatcher

---
 rtl/teller_dispatcher_pkg.sv | 9 +
 rtl/req_edge_sync.sv | 14 +
 rtl/teller_dispatcher.sv | 97 +++++++++
 tb/tb_teller_dispatcher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/teller_dispatcher_pkg.sv
// teller_dispatcher_pkg: shared constants, FSM encoding and desk-index helper
package teller_dispatcher_pkg;
    localparam int N_TELLERS = 3;
    localparam logic [3:0] TICKET_MAX = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_SETTLE} state_t;
    function automatic logic [1:0] next_desk(input logic [1:0] d);
        return (d == 2'(N_TELLERS - 1)) ? 2'd0 : d + 2'd1;
    endfunction
endpackage

// File: rtl/req_edge_sync.sv
// req_edge_sync: two-flop synchronizer with rising-edge detect for one desk button
module req_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic req_in,
    output logic rise
);
    logic [2:0] sync_q, sync_d;
    // bits 0..1 resolve metastability, bit 2 holds the previous synchronized level
    always_comb sync_d = {sync_q[1:0], req_in};
    // shift register state
    always_ff @(posedge clk) sync_q <= reset ? 3'b000 : sync_d;
    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/teller_dispatcher.sv
// teller_dispatcher: round-robin grant of waiting customers to teller desks
module teller_dispatcher
    import teller_dispatcher_pkg::*;
#(
    parameter int SERVICE_TICKS = 5,
    parameter int IDLE_TICKS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] teller_req,
    input  logic [1:0] active_tellers,
    input  logic [2:0] queue_count,
    output logic       serve,
    output logic [1:0] serve_id,
    output logic [3:0] ticket,
    output logic [2:0] teller_busy,
    output logic       idle_alarm
);
    localparam int TW = $clog2(SERVICE_TICKS + 1);
    localparam int IW = $clog2(IDLE_TICKS + 1);
    state_t state_q, state_d;
    logic [N_TELLERS-1:0] pending_q, pending_d, busy_q, busy_d, rise, enabled, grant;
    logic [N_TELLERS-1:0][TW-1:0] timer_q, timer_d;
    logic [1:0] rr_q, rr_d, serve_id_q, serve_id_d, win, idx;
    logic [3:0] ticket_q, ticket_d;
    logic [IW-1:0] idle_q, idle_d;
    logic serve_q, serve_d, found, go;

    for (genvar g = 0; g < N_TELLERS; g++) begin : g_sync
        req_edge_sync u_sync (.clk(clk), .reset(reset), .req_in(teller_req[g]), .rise(rise[g]));
    end

    // next-state: winner search from rr pointer, grant bookkeeping, busy timers and idle counter
    always_comb begin
        enabled = '0;
        for (int i = 0; i < N_TELLERS; i++) enabled[i] = 2'(i) < active_tellers;
        found = 1'b0;
        win = rr_q;
        idx = rr_q;
        for (int k = 0; k < N_TELLERS; k++) begin
            idx = 2'((int'(rr_q) + k) % N_TELLERS);
            if (!found && pending_q[idx] && enabled[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        go = (state_q == ST_IDLE) && found && (queue_count != 3'd0);
        grant = go ? (3'b001 << win) : 3'b000;
        state_d = go ? ST_SERVE : (state_q == ST_SERVE) ? ST_SETTLE : ST_IDLE;
        serve_d = go;
        serve_id_d = go ? win + 2'd1 : serve_id_q;
        ticket_d = !go ? ticket_q : (ticket_q == TICKET_MAX) ? 4'd0 : ticket_q + 4'd1;
        rr_d = go ? next_desk(win) : rr_q;
        pending_d = (pending_q | (rise & ~busy_q & enabled)) & ~grant & enabled;
        timer_d = '0;
        busy_d = '0;
        for (int i = 0; i < N_TELLERS; i++) begin
            timer_d[i] = !enabled[i] ? '0 : grant[i] ? TW'(SERVICE_TICKS) :
                         (tick && timer_q[i] != '0) ? timer_q[i] - TW'(1) : timer_q[i];
            busy_d[i] = timer_d[i] != '0;
        end
        idle_d = (queue_count == 3'd0 || busy_q != '0) ? '0 :
                 (tick && idle_q != IW'(IDLE_TICKS)) ? idle_q + IW'(1) : idle_q;
    end

    // all state and registered outputs; reset aborts any grant in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            busy_q     <= '0;
            timer_q    <= '0;
            rr_q       <= 2'd0;
            serve_q    <= 1'b0;
            serve_id_q <= 2'd0;
            ticket_q   <= 4'd0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            timer_q    <= timer_d;
            rr_q       <= rr_d;
            serve_q    <= serve_d;
            serve_id_q <= serve_id_d;
            ticket_q   <= ticket_d;
            idle_q     <= idle_d;
        end
    end

    assign serve       = serve_q;
    assign serve_id    = serve_id_q;
    assign ticket      = ticket_q;
    assign teller_busy = busy_q;
    assign idle_alarm  = idle_q == IW'(IDLE_TICKS);
endmodule

// File: tb/tb_teller_dispatcher.sv
// tb_teller_dispatcher: scenario tasks plus a scoreboard of expected grants
module tb_teller_dispatcher;
    logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic [2:0] teller_req = '0, queue_count = '0;
    logic [1:0] active_tellers = '0;
    logic serve, idle_alarm;
    logic [1:0] serve_id;
    logic [3:0] ticket;
    logic [2:0] teller_busy;
    typedef struct { logic [1:0] id; logic [3:0] tk; } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic [3:0] exp_tk = '0;

    always #5 clk = ~clk;

    teller_dispatcher dut (
        .clk(clk), .reset(reset), .tick(tick), .teller_req(teller_req),
        .active_tellers(active_tellers), .queue_count(queue_count), .serve(serve),
        .serve_id(serve_id), .ticket(ticket), .teller_busy(teller_busy), .idle_alarm(idle_alarm)
    );

    // every serve pulse must match the oldest expected grant
    always @(negedge clk) begin
        if (serve === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: serve id=%0d ticket=%0d, none expected", serve_id, ticket);
            end else begin
                e = sb.pop_front();
                if (serve_id !== e.id || ticket !== e.tk) begin
                    errors++;
                    $display("FAIL sb_grant: got id=%0d ticket=%0d, want id=%0d ticket=%0d", serve_id, ticket, e.id, e.tk);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycles(input int n); repeat (n) @(negedge clk); endtask
    task automatic do_reset;
        reset = 1'b1; teller_req = '0; tick = 1'b0;
        cycles(3);
        reset = 1'b0; exp_tk = '0;
    endtask
    task automatic press(input logic [2:0] m);
        teller_req = m; cycles(2); teller_req = '0;
    endtask
    task automatic ticks(input int n);
        repeat (n) begin tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk); end
    endtask
    task automatic expect_serve(input logic [1:0] id);
        exp_tk = (exp_tk == 4'd9) ? 4'd0 : exp_tk + 4'd1;
        sb.push_back('{id, exp_tk});
    endtask
    task automatic wait_serve(input int budget, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (serve !== 1'b1 && lat < budget);
        if (serve !== 1'b1) lat = -1;
    endtask
    task automatic count_serves(input int n, output int c);
        c = 0;
        repeat (n) begin @(negedge clk); if (serve === 1'b1) c++; end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (serve !== 1'b0) begin errors++; $display("FAIL reset_serve: got %b want 0", serve); end
        checks++; if (serve_id !== 2'd0) begin errors++; $display("FAIL reset_serve_id: got %0d want 0", serve_id); end
        checks++; if (ticket !== 4'd0) begin errors++; $display("FAIL reset_ticket: got %0d want 0", ticket); end
        checks++; if (teller_busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", teller_busy); end
        checks++; if (idle_alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", idle_alarm); end
    endtask

    task automatic test_single;
        int lat, c;
        active_tellers = 2'd3; queue_count = 3'd4;
        expect_serve(2'd2);
        press(3'b010);
        wait_serve(6, lat);
        checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL single_latency: got %0d want 1..2", lat); end
        checks++; if (teller_busy !== 3'b010) begin errors++; $display("FAIL single_busy: got %b want 010", teller_busy); end
        checks++; if (ticket !== 4'd1) begin errors++; $display("FAIL single_ticket: got %0d want 1", ticket); end
        cycles(1);
        checks++; if (serve !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", serve); end
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL single_extra_serve: got %0d want 0", c); end
        ticks(5);
        checks++; if (teller_busy !== 3'b000) begin errors++; $display("FAIL single_busy_expire: got %b want 000", teller_busy); end
    endtask

    task automatic test_round_robin;
        int lat, gap;
        do_reset;
        active_tellers = 2'd3; queue_count = 3'd4;
        expect_serve(2'd1);
        expect_serve(2'd3);
        press(3'b101);
        wait_serve(6, lat);
        checks++; if (lat < 0 || serve_id !== 2'd1) begin errors++; $display("FAIL rr_first: got lat=%0d id=%0d want id=1", lat, serve_id); end
        wait_serve(8, gap);
        checks++; if (gap < 3 || gap > 4) begin errors++; $display("FAIL rr_gap: got %0d want 3..4", gap); end
        checks++; if (serve_id !== 2'd3 || ticket !== 4'd2) begin errors++; $display("FAIL rr_second: got id=%0d ticket=%0d want id=3 ticket=2", serve_id, ticket); end
        checks++; if (teller_busy !== 3'b101) begin errors++; $display("FAIL rr_busy: got %b want 101", teller_busy); end
        ticks(5);
    endtask

    task automatic test_queue_empty;
        int lat, c;
        queue_count = 3'd0;
        press(3'b001);
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL qempty_serve: got %0d want 0", c); end
        expect_serve(2'd1);
        queue_count = 3'd2;
        wait_serve(3, lat);
        checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL qempty_latency: got %0d want 1..2", lat); end
        checks++; if (serve_id !== 2'd1) begin errors++; $display("FAIL qempty_id: got %0d want 1", serve_id); end
    endtask

    task automatic test_busy_drop;
        int lat, c;
        press(3'b001);
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL busy_press_served: got %0d want 0", c); end
        ticks(4);
        checks++; if (teller_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_4ticks: got %b want 1", teller_busy[0]); end
        ticks(1);
        checks++; if (teller_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_5ticks: got %b want 0", teller_busy[0]); end
        count_serves(4, c);
        checks++; if (c != 0) begin errors++; $display("FAIL busy_stale_pending: got %0d want 0", c); end
        expect_serve(2'd1);
        press(3'b001);
        wait_serve(6, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL busy_regrant: got timeout want serve"); end
        ticks(5);
    endtask

    task automatic test_wrap_disable;
        int lat, c, d;
        d = 1;
        while (exp_tk != 4'd9) begin
            expect_serve(2'(d + 1));
            press(3'b001 << d);
            wait_serve(6, lat);
            checks++; if (lat < 0) begin errors++; $display("FAIL wrap_fill: got timeout want serve desk %0d", d + 1); end
            ticks(5);
            d = (d + 1) % 3;
        end
        expect_serve(2'd1);
        press(3'b001);
        wait_serve(6, lat);
        checks++; if (lat < 0 || ticket !== 4'd0) begin errors++; $display("FAIL wrap_ticket: got lat=%0d ticket=%0d want 0", lat, ticket); end
        ticks(5);
        expect_serve(2'd2);
        press(3'b010);
        wait_serve(6, lat);
        checks++; if (lat < 0 || teller_busy !== 3'b010) begin errors++; $display("FAIL dis_setup: got lat=%0d busy=%b want busy 010", lat, teller_busy); end
        queue_count = 3'd0;
        press(3'b100);
        cycles(2);
        active_tellers = 2'd1;
        cycles(2);
        checks++; if (teller_busy !== 3'b000) begin errors++; $display("FAIL dis_busy_clear: got %b want 000", teller_busy); end
        queue_count = 3'd2;
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL dis_grant_disabled: got %0d want 0", c); end
        active_tellers = 2'd3;
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL dis_pending_kept: got %0d want 0", c); end
    endtask

    task automatic test_idle_alarm;
        int lat;
        queue_count = 3'd0;
        ticks(5);
        checks++; if (idle_alarm !== 1'b0) begin errors++; $display("FAIL idle_empty: got %b want 0", idle_alarm); end
        queue_count = 3'd3;
        ticks(7);
        checks++; if (idle_alarm !== 1'b0) begin errors++; $display("FAIL idle_7: got %b want 0", idle_alarm); end
        ticks(1);
        checks++; if (idle_alarm !== 1'b1) begin errors++; $display("FAIL idle_8: got %b want 1", idle_alarm); end
        ticks(2);
        checks++; if (idle_alarm !== 1'b1) begin errors++; $display("FAIL idle_saturate: got %b want 1", idle_alarm); end
        expect_serve(2'd1);
        press(3'b001);
        wait_serve(6, lat);
        cycles(1);
        checks++; if (lat < 0 || idle_alarm !== 1'b0) begin errors++; $display("FAIL idle_after_grant: got lat=%0d alarm=%b want 0", lat, idle_alarm); end
    endtask

    task automatic test_reset_abort;
        int lat, c;
        active_tellers = 2'd3; queue_count = 3'd4;
        expect_serve(2'd2);
        press(3'b010);
        wait_serve(6, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL abort_setup: got timeout want serve"); end
        reset = 1'b1;
        count_serves(3, c);
        reset = 1'b0; exp_tk = '0;
        checks++; if (c != 0) begin errors++; $display("FAIL abort_in_reset: got %0d serves want 0", c); end
        count_serves(8, c);
        checks++; if (c != 0) begin errors++; $display("FAIL abort_after_reset: got %0d serves want 0", c); end
        checks++; if (serve_id !== 2'd0 || ticket !== 4'd0 || teller_busy !== 3'b000) begin errors++; $display("FAIL abort_state: got id=%0d ticket=%0d busy=%b want 0/0/000", serve_id, ticket, teller_busy); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_queue_empty;
        test_busy_drop;
        test_wrap_disable;
        test_idle_alarm;
        test_reset_abort;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
